mask_row_serializer_vga: RTL

MASK_ROW_SERIALIZER_VGA -- requirements
Module: mask_row_serializer_vga

---
 rtl/mask_row_serializer_vga.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mask_row_serializer_vga.sv
// rtl/mask_row_serializer_vga.sv - serializes 640-bit mask rows into 32-bit beats with one-row pending buffer
module mask_row_serializer_vga #(
    parameter int COLS   = 640,
    parameter int LANE_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic [0:COLS-1]   mg_mask,
    input  logic [0:COLS-1]   mg_mask_n,
    input  logic              rp_valid,
    input  logic              out_ready,
    input  logic              clr_status,
    output logic [LANE_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic [15:0]       row_count,
    output logic              overflow,
    output logic              mask_err
);

    localparam int BEATS = COLS / LANE_W;
    localparam int BW    = $clog2(BEATS);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q, state_d;
    logic [0:COLS-1]  act_q, act_d;
    logic [0:COLS-1]  pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [15:0]      row_count_q, row_count_d;
    logic             overflow_q, overflow_d;
    logic             mask_err_q, mask_err_d;

    logic             hs;
    logic             last_beat;
    logic             row_ok;
    logic             capture;
    logic             drop;

    assign out_valid = (state_q == SEND);
    assign last_beat = (beat_q == BW'(BEATS - 1));
    assign hs        = clk_en & out_valid & out_ready;
    assign row_ok    = (mg_mask == ~mg_mask_n);
    assign out_last  = out_valid & last_beat;
    assign row_count = row_count_q;
    assign overflow  = overflow_q;
    assign mask_err  = mask_err_q;

    // The current beat always sits at the low end of the active register.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int j = 0; j < LANE_W; j++) begin
                out_data[j] = act_q[j];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        act_d        = act_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        beat_d       = beat_q;
        row_count_d  = row_count_q;
        capture      = 1'b0;
        drop         = 1'b0;
        if (clk_en) begin
            case (state_q)
                IDLE: begin
                    if (rp_valid) begin
                        act_d   = mg_mask;
                        beat_d  = '0;
                        state_d = SEND;
                        capture = 1'b1;
                    end
                end
                SEND: begin
                    if (hs && last_beat) begin
                        row_count_d = row_count_q + 16'd1;
                        beat_d      = '0;
                        if (pend_valid_q) begin
                            act_d = pend_q;
                            if (rp_valid) begin
                                pend_d  = mg_mask;
                                capture = 1'b1;
                            end else begin
                                pend_valid_d = 1'b0;
                            end
                        end else if (rp_valid) begin
                            act_d   = mg_mask;
                            capture = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        if (hs) begin
                            act_d  = act_q << LANE_W;
                            beat_d = beat_q + BW'(1);
                        end
                        if (rp_valid) begin
                            if (!pend_valid_q) begin
                                pend_d       = mg_mask;
                                pend_valid_d = 1'b1;
                                capture      = 1'b1;
                            end else begin
                                drop = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Set events win over a simultaneous clear.
    always_comb begin
        overflow_d = overflow_q;
        mask_err_d = mask_err_q;
        if (clk_en) begin
            if (drop) begin
                overflow_d = 1'b1;
            end else if (clr_status) begin
                overflow_d = 1'b0;
            end
            if (capture && !row_ok) begin
                mask_err_d = 1'b1;
            end else if (clr_status) begin
                mask_err_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            act_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            beat_q       <= '0;
            row_count_q  <= '0;
            overflow_q   <= 1'b0;
            mask_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            beat_q       <= beat_d;
            row_count_q  <= row_count_d;
            overflow_q   <= overflow_d;
            mask_err_q   <= mask_err_d;
        end
    end

endmodule
